mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the word-memory port
// of mem_access_unit. The slave modport is the unit itself; the master
// modport is the pipeline plus memory that surround it.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ReadData,
    output req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, Address, WriteData
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, ReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, Address, WriteData
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging a pipeline request to a
// word-wide memory. Sub-word loads are extracted and extended; sub-word
// stores are done as read-modify-write (ACCESS reads, MERGE writes).
// Optional feature macro MISALIGN_TRAP_EN: misaligned requests skip the
// memory and complete with resp_err=1. Without it, low address bits that a
// word/halfword op cannot use are simply ignored.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;

  logic              is_load;
  logic              is_sub_store;
  logic              misalign;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign is_load      = (op_q == OP_LW) || (op_q == OP_LH) || (op_q == OP_LHU) ||
                        (op_q == OP_LB) || (op_q == OP_LBU);
  assign is_sub_store = (op_q == OP_SH) || (op_q == OP_SB);
  assign word_addr    = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign misalign = (((op_q == OP_LW) || (op_q == OP_SW)) && (addr_q[1:0] != 2'b00)) ||
                    (((op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH)) && addr_q[0]);
  assign bus.resp_err = (state_q == RESP) && err_q;

  // Misalignment flag, decided once the request is in ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      err_q <= misalign;
    end
  end
`else
  assign misalign     = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // Select the addressed lane of the memory word and extend it per op
  always_comb begin
    lane_byte = bus.ReadData[7:0];
    case (addr_q[1:0])
      2'd1:    lane_byte = bus.ReadData[15:8];
      2'd2:    lane_byte = bus.ReadData[23:16];
      2'd3:    lane_byte = bus.ReadData[31:24];
      default: lane_byte = bus.ReadData[7:0];
    endcase
    lane_half = addr_q[1] ? bus.ReadData[31:16] : bus.ReadData[15:0];
    load_ext  = '0;
    case (op_q)
      OP_LW:   load_ext = bus.ReadData;
      OP_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_ext = {16'h0000, lane_half};
      OP_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_ext = {24'h000000, lane_byte};
      default: load_ext = '0;
    endcase
  end

  // Replace the addressed byte/halfword of the old word with the store data
  always_comb begin
    merged = word_q;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q[15:0];
      end else begin
        merged[15:0] = wdata_q[15:0];
      end
    end
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, old-word capture and load result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if ((state_q == IDLE) && bus.req_valid) begin
        op_q    <= op_e'(bus.req_op);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state_q == ACCESS) begin
        if (is_sub_store) begin
          word_q <= bus.ReadData;
        end
        rdata_q <= (is_load && !misalign) ? load_ext : '0;
      end
    end
  end

  // Next-state and Moore output decode from state and latched request only
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Address    = '0;
    bus.WriteData  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (misalign) begin
          state_d = RESP;
        end else begin
          bus.Address = word_addr;
          if (is_load) begin
            bus.MemRead = 1'b1;
            state_d     = RESP;
          end else if (op_q == OP_SW) begin
            bus.MemWrite  = 1'b1;
            bus.WriteData = wdata_q;
            state_d       = RESP;
          end else begin
            bus.MemRead = 1'b1;
            state_d     = MERGE;
          end
        end
      end
      MERGE: begin
        bus.Address   = word_addr;
        bus.MemWrite  = 1'b1;
        bus.WriteData = merged;
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: word memory model on the bus,
// transaction-level reference model, directed vectors plus random traffic.
module tb_mem_access_unit;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory the DUT talks to, and the reference copy updated per transaction
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  assign bus.ReadData = mem[bus.Address[9:2]];

  always @(negedge clk) begin
    if (bus.MemWrite) mem[bus.Address[9:2]] <= bus.WriteData;
  end

  // ---------------- reference model ----------------
  function automatic logic ref_misaligned(input logic [2:0] op, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if ((op == 3'd0 || op == 3'd5) && (a % 4 != 0)) return 1'b1;
    if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && (a % 2 != 0)) return 1'b1;
    return 1'b0;
`else
    return (op != op) || (a != a);
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] op,
                                           input logic [31:0] a);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd0:    return w;
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] sh;
    case (op)
      3'd5:    return wd;
      3'd6: begin
        sh   = 16 * ((a / 2) % 2);
        mask = 32'hFFFF << sh;
        return (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      3'd7: begin
        sh   = 8 * (a % 4);
        mask = 32'hFF << sh;
        return (old & ~mask) | ((wd & 32'hFF) << sh);
      end
      default: return old;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a);
    if (ref_misaligned(op, a)) return 2;
    if (op == 3'd6 || op == 3'd7) return 3;
    return 2;
  endfunction

  // ---------------- transaction driver (no checking) ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic err,
                       output int nrd, output int nwr, output int rd_cyc, output int wr_cyc,
                       output int clash, output int busy_ready, output logic [31:0] wr_word,
                       output logic post_rv, output logic post_rdy);
    int guard;
    lat = 0; rd = '0; err = 1'b0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0;
    clash = 0; busy_ready = 0; wr_word = '0;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int k = 1; k <= 8; k++) begin
      if (bus.MemRead) begin nrd++; if (rd_cyc == 0) rd_cyc = k; end
      if (bus.MemWrite) begin nwr++; wr_word = bus.WriteData; if (wr_cyc == 0) wr_cyc = k; end
      if (bus.MemRead && bus.MemWrite) clash++;
      if (bus.req_ready) busy_ready++;
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    post_rv  = bus.resp_valid;
    post_rdy = bus.req_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b expected 1", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.MemRead, bus.MemWrite, bus.resp_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 0000",
               {bus.resp_valid, bus.MemRead, bus.MemWrite, bus.resp_err});
    end
    checks++;
    if (bus.Address !== 32'h0 || bus.WriteData !== 32'h0 || bus.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses got addr=%h wdata=%h rdata=%h expected all 0",
               bus.Address, bus.WriteData, bus.resp_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got ready=%b rd=%b wr=%b expected 1 0 0",
               bus.req_ready, bus.MemRead, bus.MemWrite);
    end
  endtask

  task automatic test_spec_vectors;
    logic [2:0]  vop  [5] = '{3'd3, 3'd4, 3'd1, 3'd0, 3'd2};
    logic [31:0] vadr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] vexp [5] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8877,
                              32'h8877_6655, 32'h0000_6655};
    int lat, nrd, nwr, rc, wc, clash, br;
    logic [31:0] rd, ww;
    logic err, prv, prdy;
    mem[64] = 32'h8877_6655;
    ref_mem[64] = 32'h8877_6655;
    for (int i = 0; i < 5; i++) begin
      issue(vop[i], vadr[i], 32'h0, lat, rd, err, nrd, nwr, rc, wc, clash, br, ww, prv, prdy);
      checks++;
      if (rd !== vexp[i] || lat != 2) begin
        errors++;
        $display("FAIL vec%0d_load got rdata=%h lat=%0d expected %h lat=2", i, rd, lat, vexp[i]);
      end
    end
    // SB 0xAA at 0x101: read-modify-write
    issue(3'd7, 32'h101, 32'h0000_00AA, lat, rd, err, nrd, nwr, rc, wc, clash, br, ww, prv, prdy);
    ref_mem[64] = 32'h8877_AA55;
    checks++;
    if (rc != 1 || wc != 2 || nrd != 1 || nwr != 1) begin
      errors++;
      $display("FAIL sb_strobes got rd_cyc=%0d wr_cyc=%0d nrd=%0d nwr=%0d expected 1 2 1 1",
               rc, wc, nrd, nwr);
    end
    checks++;
    if (ww !== 32'h8877_AA55 || lat != 3 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sb_write got wdata=%h lat=%0d rdata=%h expected 8877aa55 3 0", ww, lat, rd);
    end
    issue(3'd0, 32'h100, 32'h0, lat, rd, err, nrd, nwr, rc, wc, clash, br, ww, prv, prdy);
    checks++;
    if (rd !== 32'h8877_AA55) begin
      errors++; $display("FAIL lw_after_sb got %h expected 8877aa55", rd);
    end
    // SW at a misaligned address
    issue(3'd5, 32'h102, 32'h1234_5678, lat, rd, err, nrd, nwr, rc, wc, clash, br, ww, prv, prdy);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (err !== 1'b1 || nwr != 0 || nrd != 0 || mem[64] !== 32'h8877_AA55 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_misaligned got err=%b nwr=%0d nrd=%0d mem=%h expected 1 0 0 8877aa55",
               err, nwr, nrd, mem[64]);
    end
`else
    ref_mem[64] = 32'h1234_5678;
    checks++;
    if (err !== 1'b0 || nwr != 1 || mem[64] !== 32'h1234_5678 || lat != 2) begin
      errors++;
      $display("FAIL sw_unaligned got err=%b nwr=%0d mem=%h lat=%0d expected 0 1 12345678 2",
               err, nwr, mem[64], lat);
    end
`endif
  endtask

  task automatic test_random;
    int lat, nrd, nwr, rc, wc, clash, br;
    int exp_rd_n, exp_wr_n, bad;
    logic [31:0] rd, ww, a, wd, exp_rd;
    logic [2:0] op;
    logic err, prv, prdy, mis;
    for (int n = 0; n < 80; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom_range(0, 1023);
      wd  = $urandom;
      mis = ref_misaligned(op, a);
      exp_rd   = (op <= 3'd4 && !mis) ? ref_load(ref_mem[a / 4], op, a) : 32'h0;
      exp_rd_n = (!mis && op != 3'd5) ? 1 : 0;
      exp_wr_n = (!mis && op >= 3'd5) ? 1 : 0;
      if (op >= 3'd5 && !mis) ref_mem[a / 4] = ref_store(ref_mem[a / 4], op, a, wd);
      issue(op, a, wd, lat, rd, err, nrd, nwr, rc, wc, clash, br, ww, prv, prdy);
      checks++;
      if (rd !== exp_rd || err !== mis) begin
        errors++;
        $display("FAIL rnd%0d_resp op=%0d addr=%h got rdata=%h err=%b expected %h %b",
                 n, op, a, rd, err, exp_rd, mis);
      end
      checks++;
      if (lat != ref_latency(op, a) || prv !== 1'b0 || prdy !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_timing op=%0d got lat=%0d post_valid=%b post_ready=%b expected %0d 0 1",
                 n, op, lat, prv, prdy, ref_latency(op, a));
      end
      checks++;
      if (nrd != exp_rd_n || nwr != exp_wr_n || clash != 0 || br != 0) begin
        errors++;
        $display("FAIL rnd%0d_strobes op=%0d got nrd=%0d nwr=%0d clash=%0d busy_ready=%0d expected %0d %0d 0 0",
                 n, op, nrd, nwr, clash, br, exp_rd_n, exp_wr_n);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mem_image got %0d differing words expected 0", bad);
    end
  endtask

  task automatic test_reset_merge;
    logic [31:0] old;
    int seen;
    old = mem[64];
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd6;
    bus.req_addr  = 32'h102;
    bus.req_wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.MemWrite !== 1'b1) begin
      errors++; $display("FAIL sh_merge_reached got MemWrite=%b expected 1", bus.MemWrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.req_ready !== 1'b1 || bus.Address !== 32'h0) begin
      errors++;
      $display("FAIL abort_immediate got wr=%b ready=%b addr=%h expected 0 1 0",
               bus.MemWrite, bus.req_ready, bus.Address);
    end
    seen = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.resp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || mem[64] !== old) begin
      errors++;
      $display("FAIL abort_effects got resp_pulses=%0d mem=%h expected 0 %h", seen, mem[64], old);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q [$];
    logic [31:0] a, e;
    logic [2:0] op;
    logic mis;
    int accepts, resps, last_acc, exp_gap, bad_gap, bad_data;
    accepts = 0; resps = 0; last_acc = -1; exp_gap = 0; bad_gap = 0; bad_data = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'($urandom_range(0, 7));
    bus.req_addr  = $urandom_range(0, 1023);
    bus.req_wdata = $urandom;
    for (int c = 0; c < 70; c++) begin
      if (bus.resp_valid) begin
        resps++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (bus.resp_rdata !== e) bad_data++;
      end
      if (bus.req_ready) begin
        if (last_acc >= 0 && c - last_acc != exp_gap) bad_gap++;
        accepts++;
        last_acc = c;
        op  = bus.req_op;
        a   = bus.req_addr;
        mis = ref_misaligned(op, a);
        exp_gap = ref_latency(op, a) + 1;
        exp_q.push_back((op <= 3'd4 && !mis) ? ref_load(ref_mem[a / 4], op, a) : 32'h0);
        if (op >= 3'd5 && !mis)
          ref_mem[a / 4] = ref_store(ref_mem[a / 4], op, a, bus.req_wdata);
      end
      @(posedge clk); #1;
      bus.req_op    = 3'($urandom_range(0, 7));
      bus.req_addr  = $urandom_range(0, 1023);
      bus.req_wdata = $urandom;
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.resp_valid) begin
        resps++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (bus.resp_rdata !== e) bad_data++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (accepts < 15 || resps != accepts) begin
      errors++; $display("FAIL b2b_count got accepts=%0d resps=%0d expected equal (>=15)", accepts, resps);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++; $display("FAIL b2b_spacing got %0d wrong gaps expected 0", bad_gap);
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL b2b_rdata got %0d wrong results expected 0", bad_data);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_spec_vectors();
    test_random();
    test_reset_merge();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
